// File: rtl/jc_phase_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : jc_phase_monitor
//  Description : Decodes a Johnson counter output into a phase index and a
//                one-hot strobe, verifies the successor sequence, declares
//                lock after a run of good steps, flags sequence breaks and
//                counts full revolutions.
//  Revision    : 1.0  initial release
// ============================================================================
module jc_phase_monitor #(
    parameter int N        = 4,
    parameter int LOCK_CNT = 3,
    parameter int CW       = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [N-1:0]             q_in,
    input  logic                     clr_err,
    output logic [$clog2(2*N)-1:0]   phase,
    output logic [2*N-1:0]           phase_oh,
    output logic                     locked,
    output logic                     err,
    output logic                     wrap,
    output logic [CW-1:0]            wrap_cnt
);

    localparam int PW = $clog2(2*N);

    localparam logic [3:0]     c_lock_cnt = 4'(LOCK_CNT);
    localparam logic [PW-1:0]  c_last     = PW'(2*N-1);
    localparam logic [2*N-1:0] c_oh_one   = {{(2*N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_UNLOCK = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2,
        ST_ERROR  = 2'd3
    } state_t;

    state_t        r_state, w_state_nx;
    logic [N-1:0]  r_q;
    logic [3:0]    r_match, w_match_nx;
    logic [PW-1:0] r_phase, w_phase_nx;
    logic          r_wrap, w_wrap_nx;
    logic [CW-1:0] r_wrap_cnt, w_wrap_cnt_nx;

    logic [N-1:0]  w_succ;
    logic          w_is_succ;
    logic          w_legal;
    logic [PW-1:0] w_dec;
    logic [3:0]    w_match_inc;

    // A legal Johnson code has at most one boundary between adjacent bits.
    function automatic logic f_legal(input logic [N-1:0] x);
        int t;
        t = 0;
        for (int i = 0; i < N-1; i++) begin
            if (x[i] != x[i+1]) t++;
        end
        return (t <= 1);
    endfunction

    // Phase index from a legal code: ones filling from the MSB count up,
    // ones draining from the MSB count down from 2N.
    function automatic logic [PW-1:0] f_decode(input logic [N-1:0] x);
        int pc;
        pc = 0;
        for (int i = 0; i < N; i++) begin
            pc += int'(x[i]);
        end
        if (x == '0)        return '0;
        else if (x[N-1])    return PW'(pc);
        else                return PW'(2*N - pc);
    endfunction

    assign w_succ      = {~r_q[0], r_q[N-1:1]};
    assign w_is_succ   = (q_in == w_succ);
    assign w_legal     = f_legal(q_in);
    assign w_dec       = f_decode(q_in);
    assign w_match_inc = r_match + 4'd1;

    // Next-state and next-value decisions for one enabled sample.
    always_comb begin
        w_state_nx    = r_state;
        w_match_nx    = r_match;
        w_phase_nx    = r_phase;
        w_wrap_nx     = 1'b0;
        w_wrap_cnt_nx = r_wrap_cnt;
        case (r_state)
            ST_UNLOCK: begin
                if (w_legal) begin
                    w_state_nx = ST_ACQ;
                    w_match_nx = '0;
                    w_phase_nx = w_dec;
                end
            end
            ST_ACQ: begin
                if (w_is_succ) begin
                    w_match_nx = w_match_inc;
                    w_phase_nx = w_dec;
                    if (w_match_inc == c_lock_cnt) w_state_nx = ST_LOCKED;
                end else if (w_legal) begin
                    w_match_nx = '0;
                    w_phase_nx = w_dec;
                end else begin
                    w_state_nx = ST_UNLOCK;
                end
            end
            ST_LOCKED: begin
                if (w_is_succ) begin
                    w_phase_nx = w_dec;
                    if ((r_phase == c_last) && (w_dec == '0)) begin
                        w_wrap_nx     = 1'b1;
                        w_wrap_cnt_nx = r_wrap_cnt + 1'b1;
                    end
                end else begin
                    // Phase keeps its last good value on a break.
                    w_state_nx = ST_ERROR;
                end
            end
            ST_ERROR: begin
                if (clr_err) begin
                    w_state_nx = ST_UNLOCK;
                    w_match_nx = '0;
                end
            end
            default: begin
                w_state_nx = ST_UNLOCK;
            end
        endcase
    end

    // State and datapath registers; a disabled edge freezes all but the wrap pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_UNLOCK;
            r_q        <= '0;
            r_match    <= '0;
            r_phase    <= '0;
            r_wrap     <= 1'b0;
            r_wrap_cnt <= '0;
        end else if (en) begin
            r_state    <= w_state_nx;
            r_q        <= q_in;
            r_match    <= w_match_nx;
            r_phase    <= w_phase_nx;
            r_wrap     <= w_wrap_nx;
            r_wrap_cnt <= w_wrap_cnt_nx;
        end else begin
            r_wrap     <= 1'b0;
        end
    end

    assign phase    = r_phase;
    assign locked   = (r_state == ST_LOCKED);
    assign err      = (r_state == ST_ERROR);
    assign phase_oh = locked ? (c_oh_one << r_phase) : '0;
    assign wrap     = r_wrap & en;
    assign wrap_cnt = r_wrap_cnt;

endmodule
`default_nettype wire

// File: tb/tb_jc_phase_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jc_phase_monitor
//  Description : Self-checking bench for jc_phase_monitor with a table-based
//                reference model of the Johnson sequence.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_jc_phase_monitor;

    localparam int N        = 4;
    localparam int LOCK_CNT = 3;
    localparam int CW       = 8;
    localparam int L        = 2*N;
    localparam int PW       = $clog2(2*N);

    localparam int M_UNLOCK = 0;
    localparam int M_ACQ    = 1;
    localparam int M_LOCKED = 2;
    localparam int M_ERROR  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [N-1:0]  q_in;
    logic          clr_err;
    logic [PW-1:0] phase;
    logic [L-1:0]  phase_oh;
    logic          locked;
    logic          err;
    logic          wrap;
    logic [CW-1:0] wrap_cnt;

    jc_phase_monitor #(.N(N), .LOCK_CNT(LOCK_CNT), .CW(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .q_in     (q_in),
        .clr_err  (clr_err),
        .phase    (phase),
        .phase_oh (phase_oh),
        .locked   (locked),
        .err      (err),
        .wrap     (wrap),
        .wrap_cnt (wrap_cnt)
    );

    always #5 clk = ~clk;

    // Table of the legal sequence; position in the table is the phase.
    logic [N-1:0] seq [L];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    int           m_mode;
    int           m_match;
    int           m_phase;
    int           m_wrap;
    int           m_wcnt;
    logic [N-1:0] m_qr;

    function automatic int idx_of(input logic [N-1:0] x);
        for (int i = 0; i < L; i++) if (seq[i] == x) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_mode = M_UNLOCK; m_match = 0; m_phase = 0;
        m_wrap = 0; m_wcnt = 0; m_qr = '0;
    endtask

    task automatic model_edge(input logic [N-1:0] q, input logic c, input logic e);
        int idx, pidx;
        logic succ_ok;
        if (!e) begin
            m_wrap = 0;
            return;
        end
        idx     = idx_of(q);
        pidx    = idx_of(m_qr);
        succ_ok = (idx >= 0) && (pidx >= 0) && (idx == (pidx + 1) % L);
        m_qr    = q;
        m_wrap  = 0;
        case (m_mode)
            M_UNLOCK: if (idx >= 0) begin m_mode = M_ACQ; m_match = 0; m_phase = idx; end
            M_ACQ: begin
                if (succ_ok) begin
                    m_match++; m_phase = idx;
                    if (m_match == LOCK_CNT) m_mode = M_LOCKED;
                end else if (idx >= 0) begin
                    m_match = 0; m_phase = idx;
                end else m_mode = M_UNLOCK;
            end
            M_LOCKED: begin
                if (succ_ok) begin
                    if (m_phase == L-1 && idx == 0) begin
                        m_wrap = 1; m_wcnt = (m_wcnt + 1) % (1 << CW);
                    end
                    m_phase = idx;
                end else m_mode = M_ERROR;
            end
            default: if (c) begin m_mode = M_UNLOCK; m_match = 0; end
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string where);
        logic [31:0] exp_oh;
        exp_oh = (m_mode == M_LOCKED) ? (32'd1 << m_phase) : 32'd0;
        check({where, ".phase"},    32'(phase),    32'(m_phase));
        check({where, ".phase_oh"}, 32'(phase_oh), exp_oh);
        check({where, ".locked"},   32'(locked),   32'(m_mode == M_LOCKED));
        check({where, ".err"},      32'(err),      32'(m_mode == M_ERROR));
        check({where, ".wrap"},     32'(wrap),     32'(m_wrap != 0 && en));
        check({where, ".wrap_cnt"}, 32'(wrap_cnt), 32'(m_wcnt));
    endtask

    task automatic step(input string where, input logic [N-1:0] q, input logic c, input logic e);
        q_in = q; clr_err = c; en = e;
        @(posedge clk);
        model_edge(q, c, e);
        @(negedge clk);
        compare_all(where);
    endtask

    initial begin
        int cur;
        int pi;
        int r;
        logic [N-1:0] qq;

        seq[0] = '0;
        for (int i = 1; i < L; i++) seq[i] = {~seq[i-1][0], seq[i-1][N-1:1]};

        // Reset held from time zero: outputs must be clear before any edge.
        rst = 1'b0; en = 1'b0; q_in = '0; clr_err = 1'b0;
        model_reset();
        #1 compare_all("reset_noedge");
        repeat (3) begin @(negedge clk); compare_all("reset_hold"); end
        rst = 1'b1;

        // Lock on 0000,1000,1100,1110.
        for (int i = 0; i < 4; i++) step("lock", seq[i], 1'b0, 1'b1);
        cur = 3;
        check("lock.locked", 32'(locked), 32'd1);
        check("lock.phase", 32'(phase), 32'd3);
        check("lock.phase_oh", 32'(phase_oh), 32'h08);

        // Eight more edges through one wrap.
        for (int j = 0; j < 8; j++) begin
            cur = (cur + 1) % L;
            step("wrap", seq[cur], 1'b0, 1'b1);
            if (cur == 0) begin
                check("wrap.pulse", 32'(wrap), 32'd1);
                check("wrap.cnt1", 32'(wrap_cnt), 32'd1);
            end
        end

        // 255 further revolutions roll the counter over to zero.
        for (int rv = 0; rv < 255; rv++) begin
            for (int j = 0; j < L; j++) begin
                cur = (cur + 1) % L;
                step("revs", seq[cur], 1'b0, 1'b1);
            end
        end
        check("rollover.cnt", 32'(wrap_cnt), 32'd0);

        // Break at phase 5 with an illegal code.
        while (cur != 5) begin cur = (cur + 1) % L; step("to5", seq[cur], 1'b0, 1'b1); end
        step("break", 4'b1010, 1'b0, 1'b1);
        check("break.err", 32'(err), 32'd1);
        check("break.locked", 32'(locked), 32'd0);
        check("break.phase", 32'(phase), 32'd5);
        check("break.phase_oh", 32'(phase_oh), 32'd0);
        repeat (5) step("err_hold", N'($urandom), 1'b0, 1'b1);
        check("err_hold.err", 32'(err), 32'd1);
        step("clr", N'($urandom), 1'b1, 1'b1);
        check("clr.err", 32'(err), 32'd0);
        for (int j = 0; j < LOCK_CNT + 1; j++) begin
            cur = (cur + 1) % L;
            step("relock", seq[cur], 1'b0, 1'b1);
        end
        check("relock.locked", 32'(locked), 32'd1);

        // Run to a wrap, then stall with a changing input.
        do begin cur = (cur + 1) % L; step("to_wrap", seq[cur], 1'b0, 1'b1); end while (cur != 0);
        repeat (4) begin
            step("stall", N'($urandom), 1'b0, 1'b0);
            check("stall.wrap", 32'(wrap), 32'd0);
        end
        step("resume", seq[1], 1'b0, 1'b1);
        check("resume.locked", 32'(locked), 32'd1);
        check("resume.err", 32'(err), 32'd0);

        // Asynchronous reset mid-run, then acquisition restart.
        #2 rst = 1'b0;
        model_reset();
        #1 compare_all("async_rst");
        @(negedge clk);
        compare_all("async_rst_hold");
        rst = 1'b1;
        step("acq", seq[1], 1'b0, 1'b1);
        step("acq", seq[2], 1'b0, 1'b1);
        step("acq_restart", 4'b0011, 1'b0, 1'b1);
        check("acq_restart.phase", 32'(phase), 32'd6);
        step("acq_illegal", 4'b1011, 1'b0, 1'b1);
        check("acq_illegal.locked", 32'(locked), 32'd0);
        for (int j = 3; j < 7; j++) step("after_illegal", seq[j], 1'b0, 1'b1);

        // Randomized traffic against the model.
        for (int k = 0; k < 600; k++) begin
            pi = idx_of(m_qr);
            r  = int'($urandom % 10);
            if (r < 7 && pi >= 0) qq = seq[(pi + 1) % L];
            else if (r < 9)       qq = seq[$urandom % L];
            else                  qq = N'($urandom);
            step("rand", qq, ($urandom % 12) == 0, ($urandom % 8) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/jc_phase_monitor.md
Name: jc_phase_monitor

Overview:
- Sits directly downstream of the ring/Johnson counter and consumes its `q` output every clock.
- Decodes the Johnson code into a binary phase index and a one-hot phase strobe.
- Checks that each new sample is the legal successor of the previous one and locks after a run of good transitions.
- Flags a sticky error on a sequence break and counts full revolutions for phase-based sequencing logic.

Parameters:
- N, 4: counter width; the Johnson sequence length is 2N.
- LOCK_CNT, 3: number of consecutive legal successor transitions needed to declare lock (1..15).
- CW, 8: width of the revolution counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset (0 = reset).
- en  in  1  sample enable; when 0, all state holds.
- q_in  in  N  Johnson counter output.
- clr_err  in  1  clears the ERROR state (level, sampled on enabled edges).
- phase  out  $clog2(2N)  decoded phase index of the last good sample.
- phase_oh  out  2N  one-hot of `phase`; all zero unless locked.
- locked  out  1  high in state LOCKED.
- err  out  1  high in state ERROR (sticky until cleared).
- wrap  out  1  one-cycle pulse when phase goes 2N-1 -> 0 while locked.
- wrap_cnt  out  CW  revolution count, modulo 2^CW.

Behaviour:
- Reset (rst=0, asynchronous): phase=0, phase_oh=0, locked=0, err=0, wrap=0, wrap_cnt=0, q_r=0, match=0, state=UNLOCK.
- Successor rule: succ(x) = {~x[0], x[N-1:1]}. For N=4 the sequence is 0000,1000,1100,1110,1111,0111,0011,0001,0000.
- Legal code: of the form 1^k 0^(N-k) or 0^k 1^(N-k).
- Phase decode (legal codes only):
  - all zeros -> 0.
  - MSB=1 -> popcount.
  - otherwise -> 2N - popcount.
- All decisions are made on rising clk edges with en=1. With en=0, every register holds and wrap is forced to 0.
- Latency: outputs are registered and reflect the q_in sampled on the previous enabled edge (1 cycle).
- q_r <= q_in on every enabled edge, in every state.
- FSM:
  - UNLOCK:
    - legal q_in -> ACQ, match=0, phase=decode(q_in).
    - illegal q_in -> stay in UNLOCK.
  - ACQ:
    - q_in == succ(q_r) -> match+1, phase updates; when match reaches LOCK_CNT -> LOCKED.
    - legal q_in that is not the successor -> stay in ACQ, match=0, phase=decode(q_in).
    - illegal q_in -> UNLOCK.
  - LOCKED:
    - q_in == succ(q_r) -> phase and phase_oh update.
    - q_in != succ(q_r), including a repeat or an illegal code -> ERROR. In the same edge: locked=0, err=1, phase_oh=0, phase holds its last good value.
  - ERROR:
    - clr_err=1 -> UNLOCK, err=0, match=0.
    - otherwise stay in ERROR; q_in is ignored apart from q_r.
- clr_err outside the ERROR state: no effect.
- Simultaneous clr_err and a bad sample while in ERROR: clear wins.
- wrap: asserted for exactly one enabled cycle when, in LOCKED, the stored phase is 2N-1 and the accepted new phase is 0. wrap_cnt increments in the same edge and wraps from 2^CW-1 to 0.
- The transition edge into LOCKED never produces wrap.
- Leaving LOCKED keeps wrap_cnt; only rst clears it.
- Reset asserted mid-operation: all outputs reach their reset values immediately (asynchronous), and the block restarts in UNLOCK on the first enabled edge after rst goes high.

Test Plan:
- Reset check: rst=0 for 3 cycles -> all outputs 0 during reset, with no clk edge needed.
- Lock: en=1, counter seeded 0000 after rst release; samples 0000,1000,1100,1110 -> locked=1 after the 4th enabled edge, with phase=3, phase_oh=8'b0000_1000.
- Wrap: continue a locked run of 8 more edges through 0001 -> 0000 -> wrap pulses for one cycle and wrap_cnt=1. Also preload 255 revolutions with CW=8 -> wrap_cnt rolls over to 0.
- Break while locked: at phase 5 (0111), drive q_in=1010 -> err=1, locked=0, phase_oh=0, phase stays 5. Hold clr_err=0 for 5 cycles -> err remains 1. Pulse clr_err -> UNLOCK, then re-lock after LOCK_CNT+1 legal samples.
- Acquisition restart: in ACQ after 1000,1100, drive 0011 (legal, not successor) -> match=0 and phase=6; drive 1011 (illegal) -> UNLOCK, locked stays 0.
- Stall: hold en=0 for 4 cycles mid-lock while q_in changes -> all outputs frozen and wrap=0. Resume with en=1 and a correct successor of q_r -> stays locked with no error.
